// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: vector/count widths,
// FSM state encoding and a small mismatch-count helper.
package truth_table_sweeper_pkg;

  localparam int NUM_VEC = 16;
  localparam int VEC_W   = 4;
  localparam int CNT_W   = 5;
  localparam int TMR_W   = 4;

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Mismatch count after folding in one more compare result; 16 is the
  // largest reachable value, so the 5-bit count never wraps.
  function automatic logic [CNT_W-1:0] count_step(input logic [CNT_W-1:0] cnt,
                                                  input logic             hit);
    return cnt + {{(CNT_W-1){1'b0}}, hit};
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle timer: load/enable down-counter. After a load, expired rises once
// the counter has been enabled for SETTLE_CYCLES-1 cycles, so a SETTLE phase
// that starts on the load edge lasts exactly SETTLE_CYCLES cycles.
module truth_table_sweeper_settle_timer
  import truth_table_sweeper_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam logic [TMR_W-1:0] LOAD_VAL = TMR_W'(SETTLE_CYCLES - 1);

  logic [TMR_W-1:0] cnt;

  // Down-count from the load value and park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives {a,b,c,d} through all 16 vectors, samples the
// block-under-test output f_in for each, and compares the captured table
// against a mask latched at start. The block under test lives beside this
// module in the lab top.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for start; vector parked at 0, results held
//   SETTLE | current vector held while the block output settles
//   SAMPLE | f_in captured into the table and compared to the mask
//   DONE   | one-cycle result strobe (done=1, busy=1), back to IDLE
//
// SETTLE_CYCLES must lie in 1..15; each vector takes SETTLE_CYCLES+1 cycles.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_VEC-1:0]  expected,
  input  logic                f_in,
  output logic                a,
  output logic                b,
  output logic                c,
  output logic                d,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [NUM_VEC-1:0]  table_out,
  output logic [CNT_W-1:0]    mismatch_cnt,
  output logic [VEC_W-1:0]    mismatch_idx
);

  state_t             state;
  logic [VEC_W-1:0]   vec;
  logic [NUM_VEC-1:0] expected_q;
  logic               timer_load;
  logic               timer_en;
  logic               timer_expired;
  logic               mismatch_now;
  logic [CNT_W-1:0]   cnt_next;

  // Timer reloads on start-accept and whenever SAMPLE moves on to the next vector.
  assign timer_load = ((state == ST_IDLE) && start) ||
                      ((state == ST_SAMPLE) && (vec != LAST_VEC));
  assign timer_en   = (state == ST_SETTLE);

  truth_table_sweeper_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Compare result for the vector being sampled; pass must see the count
  // including a mismatch on the very last vector, hence cnt_next.
  assign mismatch_now = (f_in != expected_q[vec]);
  assign cnt_next     = count_step(mismatch_cnt, mismatch_now);

  // The stimulus outputs are the registered vector counter, A as MSB.
  assign {a, b, c, d} = vec;

  // Sweep FSM with vector counter, capture/compare and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      vec          <= '0;
      expected_q   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      table_out    <= '0;
      mismatch_cnt <= '0;
      mismatch_idx <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          vec <= '0;
          if (start) begin
            expected_q   <= expected;
            table_out    <= '0;
            mismatch_cnt <= '0;
            mismatch_idx <= '0;
            pass         <= 1'b0;
            busy         <= 1'b1;
            state        <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (timer_expired) begin
            state <= ST_SAMPLE;
          end
        end

        ST_SAMPLE: begin
          table_out[vec] <= f_in;
          mismatch_cnt   <= cnt_next;
          if (mismatch_now && (mismatch_cnt == '0)) begin
            mismatch_idx <= vec;
          end
          if (vec == LAST_VEC) begin
            // Counter holds at the last vector; no wrap inside a sweep.
            done  <= 1'b1;
            pass  <= (cnt_next == '0);
            state <= ST_DONE;
          end else begin
            vec   <= vec + 1'b1;
            state <= ST_SETTLE;
          end
        end

        ST_DONE: begin
          busy  <= 1'b0;
          vec   <= '0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: one instance at the default settle time
// (block = parity or constant 1) and one at SETTLE_CYCLES=1 (block = a&b).
// Expected results are queued when a sweep is launched and popped at done.
module tb_truth_table_sweeper;

  typedef struct {
    logic [15:0] tbl;
    logic [4:0]  cnt;
    logic [3:0]  idx;
    logic        pass;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start2, start1;
  logic [15:0] exp2, exp1;
  logic        f2, f1;
  int          f_mode;
  bit          sel;

  logic a2, b2, c2, d2, busy2, done2, pass2;
  logic [15:0] tbl2;
  logic [4:0]  cnt2;
  logic [3:0]  idx2;
  logic a1, b1, c1, d1, busy1, done1, pass1;
  logic [15:0] tbl1;
  logic [4:0]  cnt1;
  logic [3:0]  idx1;

  assign f2 = (f_mode == 1) ? 1'b1 : (a2 ^ b2 ^ c2 ^ d2);
  assign f1 = a1 & b1;

  truth_table_sweeper #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .expected(exp2), .f_in(f2),
    .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2), .pass(pass2),
    .table_out(tbl2), .mismatch_cnt(cnt2), .mismatch_idx(idx2)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .expected(exp1), .f_in(f1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .pass(pass1),
    .table_out(tbl1), .mismatch_cnt(cnt1), .mismatch_idx(idx1)
  );

  logic        o_busy, o_done, o_pass;
  logic [3:0]  o_vec, o_idx;
  logic [4:0]  o_cnt;
  logic [15:0] o_tbl;
  assign o_busy = sel ? busy1 : busy2;
  assign o_done = sel ? done1 : done2;
  assign o_pass = sel ? pass1 : pass2;
  assign o_vec  = sel ? {a1, b1, c1, d1} : {a2, b2, c2, d2};
  assign o_idx  = sel ? idx1 : idx2;
  assign o_cnt  = sel ? cnt1 : cnt2;
  assign o_tbl  = sel ? tbl1 : tbl2;

  int done_pulses = 0;
  always @(negedge clk) begin
    if (o_done === 1'b1) done_pulses++;
  end

  res_t sb[$];
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input int mode, input logic [15:0] mask);
    res_t r;
    r.tbl = '0; r.cnt = '0; r.idx = '0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      logic       f;
      v = 4'(i);
      f = (mode == 1) ? 1'b1 : ^v;
      r.tbl[i] = f;
      if (f != mask[i]) begin
        if (r.cnt == 5'd0) r.idx = v;
        r.cnt = r.cnt + 5'd1;
      end
    end
    r.pass = (r.cnt == 5'd0);
    return r;
  endfunction

  task automatic drive_start(input logic v);
    if (sel) start1 = v; else start2 = v;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_pass"}, 32'(o_pass), 32'd0);
    check({tag, "_vec"},  32'(o_vec),  32'd0);
    check({tag, "_tbl"},  32'(o_tbl),  32'd0);
    check({tag, "_cnt"},  32'(o_cnt),  32'd0);
    check({tag, "_idx"},  32'(o_idx),  32'd0);
  endtask

  // One full sweep on the selected instance; optional start pokes mid-sweep.
  task automatic sweep(input string tag, input logic [15:0] mask, input bit poke, input res_t want);
    int   s, lat, d0;
    bit   busy_ok, vec_ok, seen;
    res_t r;
    s = sel ? 1 : 2;
    sb.push_back(want);
    d0 = done_pulses;
    @(negedge clk);
    if (sel) exp1 = mask; else exp2 = mask;
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    if (sel) exp1 = ~mask; else exp2 = ~mask;
    busy_ok = 1; vec_ok = 1; seen = 0; lat = 0;
    for (int k = 0; k < 200; k++) begin
      if (o_busy !== 1'b1) busy_ok = 0;
      if ((k < 16 * (s + 1)) && (o_vec !== 4'(k / (s + 1)))) vec_ok = 0;
      if (o_done === 1'b1) begin
        seen = 1;
        lat  = k + 1;
        break;
      end
      drive_start(poke && (k == 10 || k == 30));
      @(negedge clk);
    end
    drive_start(1'b0);
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(16 * (s + 1) + 1));
    check({tag, "_busy_cont"}, 32'(busy_ok), 32'd1);
    check({tag, "_vec_seq"}, 32'(vec_ok), 32'd1);
    r = sb.pop_front();
    check({tag, "_table"}, 32'(o_tbl), 32'(r.tbl));
    check({tag, "_cnt"},   32'(o_cnt), 32'(r.cnt));
    check({tag, "_idx"},   32'(o_idx), 32'(r.idx));
    check({tag, "_pass"},  32'(o_pass), 32'(r.pass));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(o_done), 32'd0);
    check({tag, "_busy_after"}, 32'(o_busy), 32'd0);
    check({tag, "_table_hold"}, 32'(o_tbl), 32'(r.tbl));
    check({tag, "_pass_hold"},  32'(o_pass), 32'(r.pass));
    check({tag, "_done_count"}, 32'(done_pulses - d0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t rr;
    logic [15:0] rmask;
    int d0;
    rst = 1'b1; start2 = 1'b0; start1 = 1'b0; exp2 = '0; exp1 = '0;
    f_mode = 0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset2");
    sel = 1'b1;
    check_reset_values("reset1");
    sel = 1'b0;
    rst = 1'b0;

    sweep("t1_parity",   16'h6996, 0, '{16'h6996, 5'd0, 4'd0, 1'b1});
    sweep("t2_bit0",     16'h6997, 0, '{16'h6996, 5'd1, 4'd0, 1'b0});
    sweep("t2_bit15",    16'hE996, 0, '{16'h6996, 5'd1, 4'd15, 1'b0});
    f_mode = 1;
    sweep("t3_const1",   16'h0000, 0, '{16'hFFFF, 5'd16, 4'd0, 1'b0});
    f_mode = 0;
    sweep("t4_pokes",    16'h6996, 1, '{16'h6996, 5'd0, 4'd0, 1'b1});

    // Reset partway through a sweep.
    @(negedge clk);
    exp2 = 16'h6996; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    d0 = done_pulses;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("t5_midreset");
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("t5_no_done", 32'(done_pulses - d0), 32'd0);
    check("t5_idle_busy", 32'(o_busy), 32'd0);
    sweep("t5_clean",    16'h6996, 0, '{16'h6996, 5'd0, 4'd0, 1'b1});

    rmask = 16'($urandom);
    rr = model(0, rmask);
    sweep("rand_mask", rmask, 0, rr);

    sel = 1'b1;
    sweep("t6_and",      16'hF000, 0, '{16'hF000, 5'd0, 4'd0, 1'b1});
    sweep("t6_and_miss", 16'h7000, 0, '{16'hF000, 5'd1, 4'd15, 1'b0});

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
